// File: rtl/farrow_mu_scheduler_if.sv
// farrow_mu_scheduler_if: run control, input sample handshake, datapath strobe and mu command bundle.
interface farrow_mu_scheduler_if #(parameter int BITS = 32, INT_W = 4, FRAC_W = 16);
    logic                    enable;
    logic [INT_W+FRAC_W-1:0] step;
    logic                    s_valid;
    logic                    s_ready;
    logic [BITS-1:0]         s_data;
    logic                    dp_shift;
    logic [BITS-1:0]         dp_x;
    logic                    m_valid;
    logic                    m_ready;
    logic [FRAC_W-1:0]       m_mu;
    logic                    cfg_err;
    logic [1:0]              state;
    modport master (output enable, step, s_valid, s_data, m_ready,
                    input s_ready, dp_shift, dp_x, m_valid, m_mu, cfg_err, state);
    modport slave (input enable, step, s_valid, s_data, m_ready,
                   output s_ready, dp_shift, dp_x, m_valid, m_mu, cfg_err, state);
endinterface

// File: rtl/farrow_mu_scheduler.sv
// farrow_mu_scheduler: paces input samples and mu commands for a Farrow interpolator
// from a fixed-point phase accumulator that advances by step on every issued output.
module farrow_mu_scheduler #(
    parameter int TAPS = 12,
    parameter int BITS = 32,
    parameter int INT_W = 4,
    parameter int FRAC_W = 16
) (
    input logic clk,
    input logic rstn,
    farrow_mu_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;
    localparam int SW = INT_W + FRAC_W;
    localparam int AW = SW + 1;
    localparam int CW = $clog2(TAPS + 1);
    state_t        st, st_d;
    logic [AW-1:0] acc, acc_d;
    logic [SW-1:0] step_q, step_d;
    logic [CW-1:0] fill_cnt, fill_d;
    logic          err, err_d, accept, fire;
    logic [INT_W:0] acc_int;
    assign acc_int = acc[AW-1:FRAC_W];
    assign accept = bus.s_valid && bus.s_ready;
    assign fire = bus.m_valid && bus.m_ready;
    always_comb begin
        bus.s_ready = bus.enable && (st == FILL || (st == RUN && acc_int != '0));
        bus.m_valid = bus.enable && st == RUN && acc_int == '0;
        bus.m_mu = acc[FRAC_W-1:0];
        bus.cfg_err = err;
        bus.state = st;
        st_d = st;
        acc_d = acc;
        step_d = step_q;
        fill_d = fill_cnt;
        err_d = err;
        if (!bus.enable) begin
            st_d = IDLE;
            acc_d = '0;
            fill_d = '0;
            err_d = 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (bus.step == '0) begin
                        err_d = 1'b1;
                    end else begin
                        st_d = FILL;
                        step_d = bus.step;
                        acc_d = '0;
                        fill_d = '0;
                    end
                end
                FILL: begin
                    if (accept) begin
                        fill_d = fill_cnt + 1'b1;
                        st_d = fill_cnt == CW'(TAPS - 1) ? RUN : FILL;
                        acc_d = '0;
                    end
                end
                RUN: begin
                    // fire and accept never coincide: s_ready and m_valid split on acc_int==0
                    if (fire) acc_d = acc + AW'(step_q);
                    else if (accept) acc_d = acc - (AW'(1) << FRAC_W);
                end
                default: st_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            st <= IDLE;
            acc <= '0;
            step_q <= '0;
            fill_cnt <= '0;
            err <= 1'b0;
            bus.dp_shift <= 1'b0;
            bus.dp_x <= '0;
        end else begin
            st <= st_d;
            acc <= acc_d;
            step_q <= step_d;
            fill_cnt <= fill_d;
            err <= err_d;
            bus.dp_shift <= accept;
            if (accept) bus.dp_x <= bus.s_data;
        end
    end
endmodule

// File: tb/tb_farrow_mu_scheduler.sv
// tb_farrow_mu_scheduler: randomized handshakes checked against an ideal resampling-time model
// (output k sits at input position k*step; its mu is the fractional part of that position).
module tb_farrow_mu_scheduler;
    localparam int TAPS = 12;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int errors = 0;
    int mode = 0;
    int fills = 0;
    longint n = 0;
    longint k = 0;
    longint step_m = 0;
    bit err_m = 0;
    bit prev_acc = 0;
    logic [31:0] exp_dpx = '0;
    logic [15:0] mus[$];
    farrow_mu_scheduler_if #(.BITS(32), .INT_W(4), .FRAC_W(16)) bus();
    farrow_mu_scheduler #(.TAPS(TAPS), .BITS(32), .INT_W(4), .FRAC_W(16)) dut (
        .clk(clk), .rstn(rstn), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask
    // called at a falling edge; drives one cycle, checks it, then models the rising edge
    task automatic cycle(input int pv, input int pr);
        bit exp_sr, exp_mv, acc, fire;
        longint pos;
        logic [15:0] exp_mu;
        bus.s_valid = $urandom_range(99) < pv;
        bus.s_data = $urandom;
        bus.m_ready = $urandom_range(99) < pr;
        if (mode != 0) bus.step = 20'($urandom);
        #1;
        pos = k * step_m;
        exp_sr = bus.enable && (mode == 1 || (mode == 2 && n != (pos >> 16)));
        exp_mv = bus.enable && mode == 2 && n == (pos >> 16);
        exp_mu = 16'(pos);
        chk("state", 64'(bus.state), 64'(mode));
        chk("s_ready", 64'(bus.s_ready), 64'(exp_sr));
        chk("m_valid", 64'(bus.m_valid), 64'(exp_mv));
        chk("cfg_err", 64'(bus.cfg_err), 64'(err_m));
        chk("dp_shift", 64'(bus.dp_shift), 64'(prev_acc));
        chk("dp_x", 64'(bus.dp_x), 64'(exp_dpx));
        if (exp_mv) chk("m_mu", 64'(bus.m_mu), 64'(exp_mu));
        acc = bus.s_valid && exp_sr;
        fire = exp_mv && bus.m_ready;
        if (fire) mus.push_back(bus.m_mu);
        prev_acc = acc;
        if (acc) exp_dpx = bus.s_data;
        @(negedge clk);
        if (!bus.enable) begin
            mode = 0;
            err_m = 0;
        end else if (mode == 0) begin
            if (bus.step == '0) err_m = 1;
            else begin
                mode = 1;
                fills = 0;
                step_m = longint'(bus.step);
            end
        end else if (mode == 1) begin
            if (acc) fills++;
            if (fills == TAPS) begin
                mode = 2;
                n = 0;
                k = 0;
            end
        end else begin
            if (acc) n++;
            if (fire) k++;
        end
    endtask
    task automatic do_reset(input int cyc);
        rstn = 1'b0;
        bus.s_valid = 1'b1;
        repeat (cyc) @(negedge clk);
        #1;
        chk("rst_state", 64'(bus.state), 64'd0);
        chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_m_mu", 64'(bus.m_mu), 64'd0);
        chk("rst_dp_shift", 64'(bus.dp_shift), 64'd0);
        chk("rst_dp_x", 64'(bus.dp_x), 64'd0);
        chk("rst_cfg_err", 64'(bus.cfg_err), 64'd0);
        mode = 0;
        err_m = 0;
        prev_acc = 0;
        exp_dpx = '0;
        rstn = 1'b1;
    endtask
    task automatic start(input logic [19:0] s);
        bus.enable = 1'b0;
        cycle(50, 100);
        bus.step = s;
        bus.enable = 1'b1;
        mus.delete();
    endtask
    initial begin
        bus.enable = 1'b0;
        bus.step = '0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = 1'b0;
        @(negedge clk);
        do_reset(3);
        start(20'h10000);
        repeat (40) cycle(100, 100);
        chk("unit_mu0", 64'(mus[0]), 64'h0);
        chk("unit_mu2", 64'(mus[2]), 64'h0);
        start(20'h06DB6);
        repeat (24) cycle(100, 100);
        chk("frac_mu1", 64'(mus[1]), 64'h6DB6);
        chk("frac_mu2", 64'(mus[2]), 64'hDB6C);
        chk("frac_mu3", 64'(mus[3]), 64'h4922);
        start(20'h28000);
        repeat (30) cycle(100, 100);
        chk("dec_mu0", 64'(mus[0]), 64'h0);
        chk("dec_mu1", 64'(mus[1]), 64'h8000);
        chk("dec_mu2", 64'(mus[2]), 64'h0);
        start(20'h06DB6);
        repeat (14) cycle(100, 100);
        repeat (5) cycle(100, 0);
        repeat (10) cycle(100, 100);
        chk("stall_mu1", 64'(mus[1]), 64'h6DB6);
        start(20'h0);
        repeat (3) cycle(50, 50);
        chk("cfg_err_set", 64'(bus.cfg_err), 64'd1);
        bus.enable = 1'b0;
        repeat (2) cycle(50, 50);
        chk("cfg_err_clr", 64'(bus.cfg_err), 64'd0);
        for (int i = 0; i < 6; i++) begin
            start(i == 0 ? 20'h00800 : 20'($urandom_range(1, 20'h3FFFF)));
            repeat (150) cycle(70, 70);
        end
        start(20'h10000);
        cycle(100, 100);
        for (int i = 0; i < 20 && fills < 7; i++) cycle(100, 100);
        chk("pre_rst_fills", 64'(fills), 64'd7);
        do_reset(2);
        repeat (30) cycle(100, 100);
        chk("post_rst_state", 64'(bus.state), 64'd2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/farrow_mu_scheduler.md
FARROW_MU_SCHEDULER -- requirements
Module: farrow_mu_scheduler

Interface
REQ-001 SHALL have parameter TAPS, default 12, meaning input samples needed to fill the Farrow delay line.
REQ-002 SHALL have parameter BITS, default 32, meaning sample word width (single-precision bit pattern, passed through untouched).
REQ-003 SHALL have parameter INT_W, default 4, meaning integer bits of the step and phase values.
REQ-004 SHALL have parameter FRAC_W, default 16, meaning fraction bits of the step, phase and mu values.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port enable, input, 1 bit: run request; low aborts to IDLE.
REQ-008 SHALL have port step, input, INT_W+FRAC_W bits: unsigned Q(INT_W.FRAC_W) input samples per output.
REQ-009 SHALL have ports s_valid (input, 1), s_ready (output, 1) and s_data (input, BITS): input sample handshake.
REQ-010 SHALL have ports dp_shift (output, 1) and dp_x (output, BITS): delay-line shift strobe and sample to the datapath.
REQ-011 SHALL have ports m_valid (output, 1), m_ready (input, 1) and m_mu (output, FRAC_W): fractional-interval command to the datapath.
REQ-012 SHALL have port cfg_err, output, 1 bit: illegal step flag.
REQ-013 SHALL have port state, output, 2 bits: IDLE=0, FILL=1, RUN=2.

Function
REQ-014 SHALL accept an input sample only on a cycle with s_valid=1 and s_ready=1.
REQ-015 SHALL register each accepted sample: dp_shift=1 and dp_x=s_data on the cycle after acceptance; otherwise dp_shift=0 and dp_x holds.
REQ-016 SHALL, in IDLE, drive s_ready=0 and m_valid=0.
REQ-017 SHALL, in IDLE with enable=1 and step!=0, latch step_q=step, clear the phase accumulator and fill_cnt, and go to FILL.
REQ-018 SHALL, in IDLE with enable=1 and step==0, stay in IDLE with cfg_err=1; cfg_err is sticky until enable=0 or reset.
REQ-019 SHALL, in FILL, drive s_ready=1 and m_valid=0, and increment fill_cnt on each accept.
REQ-020 SHALL go from FILL to RUN on the TAPS-th accept, with acc_int=0 and acc_frac=0.
REQ-021 SHALL, in RUN with acc_int>0, drive s_ready=1 and m_valid=0, and decrement acc_int by 1 per accept.
REQ-022 SHALL, in RUN with acc_int==0, drive s_ready=0, m_valid=1 and m_mu=acc_frac.
REQ-023 SHALL, on m_valid and m_ready, set {acc_int,acc_frac} += step_q.
REQ-024 SHALL size the accumulator at INT_W+1 integer bits so the sum never wraps.
REQ-025 SHALL hold m_valid and m_mu stable while m_valid=1 and m_ready=0.
REQ-026 SHALL ignore step changes outside the IDLE-to-FILL transition.
REQ-027 SHALL, on enable=0 in any state, enter IDLE next cycle, clear the accumulator, fill_cnt and cfg_err, and drop s_ready and m_valid that cycle; a sample accepted on that cycle still produces its dp_shift.
REQ-028 SHALL allow step<1.0 (upsampling: several outputs per input) and step>=1.0 (several inputs per output), with no bubble cycles in RUN except those caused by the handshakes.

Reset
REQ-029 SHALL, while rstn=0 at a clk edge, set state=IDLE, s_ready=0, m_valid=0, m_mu=0, dp_shift=0, dp_x=0, cfg_err=0, step_q=0, accumulator=0 and fill_cnt=0.
REQ-030 SHALL apply rstn=0 arriving mid-FILL or mid-RUN identically, discarding all progress; a new full TAPS fill is then required.

Verification
REQ-031 SHALL cover step=0x10000 (1.0) with always-ready handshakes: 12 fill accepts, then alternating one m_mu=0x0000 output and one input accept.
REQ-032 SHALL cover step=0x06DB6 (about 3/7): after fill, m_mu sequence 0x0000, 0x6DB6, 0xDB6C, then one input accept, then 0x4922.
REQ-033 SHALL cover step=0x28000 (2.5): m_mu=0x0000, 2 accepts, m_mu=0x8000, 3 accepts, m_mu=0x0000.
REQ-034 SHALL cover m_ready=0 for 5 cycles in RUN: m_valid=1 and m_mu constant, s_ready=0, no dp_shift, and the accumulator advances once after m_ready=1.
REQ-035 SHALL cover enable=1 with step=0: cfg_err=1, state=IDLE, s_ready=0; dropping enable clears cfg_err.
REQ-036 SHALL cover rstn=0 after 7 fill accepts, then enable held: all outputs at reset values, and 12 new accepts are needed before the first m_valid.
